ps2_keycode_rx: RTL and testbench

Parametrised PS/2 keyboard receiver. It synchronises and debounces the keyboard clock and data lines, and checks each 11-bit frame for start, parity and stop bits. Valid bytes are decoded into key events: E0/F0 prefixes fold into `ext`/`brk` flags. Events are buffered in a FIFO with a valid/ready pop port, so the CPU-side I/O logic can drain keys at its own pace. Error counters and a raw-byte strobe (for blinkenlights/debug) are exposed.

---
 rtl/ps2_keycode_rx.sv | 197 +++++++++++++++++++
 tb/tb_ps2_keycode_rx.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/ps2_keycode_rx.sv
// PS/2 keyboard receiver: line filtering, 11-bit frame checking, E0/F0 prefix folding,
// and a first-word-fall-through event FIFO with saturating error counters.
module ps2_keycode_rx #(
  parameter int CLK_FREQ        = 36_000_000,
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int TIMEOUT_US      = 2000,
  parameter int FIFO_DEPTH      = 8,
  parameter int ERR_CNT_WIDTH   = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         ps2_clk,
  input  logic                         ps2_data,
  output logic                         evt_valid,
  input  logic                         evt_ready,
  output logic [7:0]                   evt_code,
  output logic                         evt_ext,
  output logic                         evt_brk,
  output logic [7:0]                   raw_code,
  output logic                         raw_new,
  output logic [ERR_CNT_WIDTH-1:0]     parity_err_cnt,
  output logic [ERR_CNT_WIDTH-1:0]     frame_err_cnt,
  output logic                         overflow,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
  input  logic                         clr_err
);

  localparam int TIMEOUT_CYCLES = CLK_FREQ / 1_000_000 * TIMEOUT_US;
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int AW   = $clog2(FIFO_DEPTH);

  function automatic logic [ERR_CNT_WIDTH-1:0] sat_inc(input logic [ERR_CNT_WIDTH-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  // index 0 = ps2_clk, index 1 = ps2_data
  logic [1:0]      pin_s0, pin_s1, filt;
  logic [DB_W-1:0] db_cnt [2];
  logic            clk_prev;
  logic            fall;

  logic [3:0]      bit_cnt;
  logic [7:0]      shreg;
  logic            par;
  logic [TO_W-1:0] to_cnt;
  logic            ext_pend, brk_pend;
  logic            push_vld;
  logic [9:0]      push_data;

  logic start_err, stop_chk, par_bad, stop_bad, good, timeout, fe_inc, pe_inc;

  // Stage: synchroniser and debounce
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pin_s0    <= '1;
      pin_s1    <= '1;
      filt      <= '1;
      db_cnt[0] <= '0;
      db_cnt[1] <= '0;
      clk_prev  <= 1'b1;
    end else begin
      pin_s0   <= {ps2_data, ps2_clk};
      pin_s1   <= pin_s0;
      clk_prev <= filt[0];
      for (int i = 0; i < 2; i++) begin
        if (pin_s1[i] != filt[i]) begin
          if (db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
            filt[i]   <= pin_s1[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + 1'b1;
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  always_comb begin
    fall      = clk_prev & ~filt[0];
    start_err = fall && (bit_cnt == 4'd0) && filt[1];
    stop_chk  = fall && (bit_cnt == 4'd10);
    par_bad   = stop_chk && !par;
    stop_bad  = stop_chk && par && !filt[1];
    good      = stop_chk && par && filt[1];
    timeout   = !fall && (bit_cnt != 4'd0) && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
    fe_inc    = start_err | stop_bad | timeout;
    pe_inc    = par_bad;
  end

  // Stage: frame reception and prefix decode (results visible in D+1)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt        <= '0;
      shreg          <= '0;
      par            <= 1'b0;
      to_cnt         <= '0;
      raw_code       <= '0;
      raw_new        <= 1'b0;
      ext_pend       <= 1'b0;
      brk_pend       <= 1'b0;
      push_vld       <= 1'b0;
      push_data      <= '0;
      parity_err_cnt <= '0;
      frame_err_cnt  <= '0;
    end else begin
      raw_new  <= 1'b0;
      push_vld <= 1'b0;

      if (fall) begin
        to_cnt <= '0;
        if (bit_cnt == 4'd0) begin
          par <= 1'b0;
          if (!filt[1]) bit_cnt <= 4'd1;
        end else if (bit_cnt == 4'd10) begin
          bit_cnt <= 4'd0;
        end else begin
          bit_cnt <= bit_cnt + 4'd1;
          par     <= par ^ filt[1];
          if (bit_cnt <= 4'd8) shreg <= {filt[1], shreg[7:1]};
        end
      end else if (bit_cnt != 4'd0) begin
        if (timeout) begin
          bit_cnt <= 4'd0;
          to_cnt  <= '0;
        end else begin
          to_cnt <= to_cnt + 1'b1;
        end
      end else begin
        to_cnt <= '0;
      end

      if (good) begin
        raw_new  <= 1'b1;
        raw_code <= shreg;
        if (shreg == 8'hE0) begin
          ext_pend <= 1'b1;
        end else if (shreg == 8'hF0) begin
          brk_pend <= 1'b1;
        end else begin
          push_vld  <= 1'b1;
          push_data <= {ext_pend, brk_pend, shreg};
          ext_pend  <= 1'b0;
          brk_pend  <= 1'b0;
        end
      end

      if (fe_inc | pe_inc) begin
        ext_pend <= 1'b0;
        brk_pend <= 1'b0;
      end

      if (clr_err)     parity_err_cnt <= '0;
      else if (pe_inc) parity_err_cnt <= sat_inc(parity_err_cnt);
      if (clr_err)     frame_err_cnt  <= '0;
      else if (fe_inc) frame_err_cnt  <= sat_inc(frame_err_cnt);
    end
  end

  logic [9:0] mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic [9:0]  head;
  logic        full, pop, push_ok;

  always_comb begin
    fifo_level = wr_ptr - rd_ptr;
    full       = (fifo_level == (AW+1)'(FIFO_DEPTH));
    evt_valid  = (fifo_level != '0);
    pop        = evt_valid & evt_ready;
    push_ok    = push_vld & (~full | pop);
    head       = mem[rd_ptr[AW-1:0]];
    evt_code   = evt_valid ? head[7:0] : 8'h00;
    evt_brk    = evt_valid & head[8];
    evt_ext    = evt_valid & head[9];
  end

  // Stage: event FIFO (write at end of D+1)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (clr_err)                         overflow <= 1'b0;
      else if (push_vld && full && !pop)   overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: tb/tb_ps2_keycode_rx.sv
// Directed bench for ps2_keycode_rx with a scaled clock (1 cycle per us) so frames stay short.
module tb_ps2_keycode_rx;
  localparam int H   = 8;    // half bit period in clk cycles
  localparam int CNW = 8;

  logic clk = 0, rst = 0, ps2_clk = 1, ps2_data = 1, evt_ready = 0, clr_err = 0;
  logic evt_valid, evt_ext, evt_brk, raw_new, overflow;
  logic [7:0] evt_code, raw_code;
  logic [CNW-1:0] parity_err_cnt, frame_err_cnt;
  logic [2:0] fifo_level;

  int checks = 0, errors = 0;
  int cyc = 0, raw_cnt = 0, raw_cyc = 0, vld_cyc = 0;
  logic vld_q = 0;

  ps2_keycode_rx #(
    .CLK_FREQ(1_000_000), .DEBOUNCE_CYCLES(3), .TIMEOUT_US(100),
    .FIFO_DEPTH(4), .ERR_CNT_WIDTH(CNW)
  ) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_code(evt_code),
    .evt_ext(evt_ext), .evt_brk(evt_brk), .raw_code(raw_code), .raw_new(raw_new),
    .parity_err_cnt(parity_err_cnt), .frame_err_cnt(frame_err_cnt),
    .overflow(overflow), .fifo_level(fifo_level), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc++;
    if (raw_new === 1'b1) begin
      raw_cnt++;
      raw_cyc = cyc;
    end
    if (evt_valid === 1'b1 && vld_q !== 1'b1) vld_cyc = cyc;
    vld_q = evt_valid;
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 0; ps2_clk = 1; ps2_data = 1; evt_ready = 0; clr_err = 0;
    repeat (3) @(negedge clk);
    rst = 1;
    repeat (10) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] code, input logic par_flip, input int nbits);
    logic [10:0] bits;
    bits = {1'b1, (~(^code)) ^ par_flip, code, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = bits[i];
      repeat (H) @(negedge clk);
      ps2_clk = 0;
      repeat (H) @(negedge clk);
      ps2_clk = 1;
    end
    ps2_data = 1;
    repeat (30) @(negedge clk);
  endtask

  task automatic pop_one();
    evt_ready = 1;
    @(negedge clk);
    evt_ready = 0;
  endtask

  task automatic test_reset();
    rst = 0;
    repeat (2) @(negedge clk);
    checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL rst_evt_valid got %0h want 0", evt_valid); end
    checks++; if (raw_new !== 1'b0) begin errors++; $display("FAIL rst_raw_new got %0h want 0", raw_new); end
    checks++; if (raw_code !== 8'h00) begin errors++; $display("FAIL rst_raw_code got %0h want 0", raw_code); end
    checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL rst_level got %0d want 0", fifo_level); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_overflow got %0h want 0", overflow); end
    checks++; if (parity_err_cnt !== 8'd0 || frame_err_cnt !== 8'd0) begin errors++; $display("FAIL rst_cnts got %0d/%0d want 0/0", parity_err_cnt, frame_err_cnt); end
    checks++; if ({evt_code, evt_ext, evt_brk} !== 10'd0) begin errors++; $display("FAIL rst_evt got %0h want 0", {evt_code, evt_ext, evt_brk}); end
    rst = 1;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_single_make();
    int r0;
    do_reset();
    r0 = raw_cnt;
    send_frame(8'h1C, 1'b0, 11);
    checks++; if (raw_cnt - r0 !== 1) begin errors++; $display("FAIL single_raw_pulses got %0d want 1", raw_cnt - r0); end
    checks++; if (raw_code !== 8'h1C) begin errors++; $display("FAIL single_raw_code got %0h want 1c", raw_code); end
    checks++; if (vld_cyc - raw_cyc !== 1) begin errors++; $display("FAIL single_latency got %0d want 1", vld_cyc - raw_cyc); end
    checks++; if ({evt_valid, evt_ext, evt_brk, evt_code} !== {3'b100, 8'h1C}) begin errors++; $display("FAIL single_evt got %0h want %0h", {evt_valid, evt_ext, evt_brk, evt_code}, {3'b100, 8'h1C}); end
    checks++; if (fifo_level !== 3'd1) begin errors++; $display("FAIL single_level got %0d want 1", fifo_level); end
    checks++; if (parity_err_cnt !== 8'd0 || frame_err_cnt !== 8'd0) begin errors++; $display("FAIL single_cnts got %0d/%0d want 0/0", parity_err_cnt, frame_err_cnt); end
    pop_one();
    checks++; if (evt_valid !== 1'b0 || fifo_level !== 3'd0) begin errors++; $display("FAIL single_pop got v=%0h l=%0d want v=0 l=0", evt_valid, fifo_level); end
    pop_one();
    checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL empty_pop_level got %0d want 0", fifo_level); end
  endtask

  task automatic test_prefix();
    int r0;
    do_reset();
    r0 = raw_cnt;
    send_frame(8'hF0, 1'b0, 11);
    send_frame(8'h1C, 1'b0, 11);
    send_frame(8'hE0, 1'b0, 11);
    send_frame(8'hF0, 1'b0, 11);
    send_frame(8'h75, 1'b0, 11);
    checks++; if (raw_cnt - r0 !== 5) begin errors++; $display("FAIL prefix_raw_pulses got %0d want 5", raw_cnt - r0); end
    checks++; if (fifo_level !== 3'd2) begin errors++; $display("FAIL prefix_level got %0d want 2", fifo_level); end
    checks++; if ({evt_valid, evt_ext, evt_brk, evt_code} !== {3'b101, 8'h1C}) begin errors++; $display("FAIL prefix_evt0 got %0h want %0h", {evt_valid, evt_ext, evt_brk, evt_code}, {3'b101, 8'h1C}); end
    pop_one();
    checks++; if ({evt_valid, evt_ext, evt_brk, evt_code} !== {3'b111, 8'h75}) begin errors++; $display("FAIL prefix_evt1 got %0h want %0h", {evt_valid, evt_ext, evt_brk, evt_code}, {3'b111, 8'h75}); end
    pop_one();
    checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL prefix_drained got %0h want 0", evt_valid); end
  endtask

  task automatic test_parity();
    int r0;
    do_reset();
    r0 = raw_cnt;
    send_frame(8'h1C, 1'b1, 11);
    checks++; if (parity_err_cnt !== 8'd1) begin errors++; $display("FAIL parity_cnt got %0d want 1", parity_err_cnt); end
    checks++; if (raw_cnt - r0 !== 0 || fifo_level !== 3'd0) begin errors++; $display("FAIL parity_no_byte got raw=%0d lvl=%0d want 0/0", raw_cnt - r0, fifo_level); end
    checks++; if (frame_err_cnt !== 8'd0) begin errors++; $display("FAIL parity_frame_cnt got %0d want 0", frame_err_cnt); end
    send_frame(8'hE0, 1'b0, 11);
    send_frame(8'h33, 1'b1, 11);
    send_frame(8'h75, 1'b0, 11);
    checks++; if (parity_err_cnt !== 8'd2) begin errors++; $display("FAIL parity_cnt2 got %0d want 2", parity_err_cnt); end
    checks++; if ({evt_valid, evt_ext, evt_brk, evt_code} !== {3'b100, 8'h75}) begin errors++; $display("FAIL parity_ext_cleared got %0h want %0h", {evt_valid, evt_ext, evt_brk, evt_code}, {3'b100, 8'h75}); end
    checks++; if (fifo_level !== 3'd1) begin errors++; $display("FAIL parity_level got %0d want 1", fifo_level); end
  endtask

  task automatic test_timeout_glitch();
    do_reset();
    send_frame(8'h29, 1'b0, 5);
    repeat (150) @(negedge clk);
    checks++; if (frame_err_cnt !== 8'd1) begin errors++; $display("FAIL timeout_cnt got %0d want 1", frame_err_cnt); end
    send_frame(8'h29, 1'b0, 11);
    checks++; if ({evt_valid, evt_ext, evt_brk, evt_code} !== {3'b100, 8'h29}) begin errors++; $display("FAIL timeout_next got %0h want %0h", {evt_valid, evt_ext, evt_brk, evt_code}, {3'b100, 8'h29}); end
    checks++; if (frame_err_cnt !== 8'd1 || parity_err_cnt !== 8'd0) begin errors++; $display("FAIL timeout_cnts got %0d/%0d want 1/0", frame_err_cnt, parity_err_cnt); end
    ps2_clk = 0;
    repeat (2) @(negedge clk);
    ps2_clk = 1;
    repeat (20) @(negedge clk);
    checks++; if (frame_err_cnt !== 8'd1) begin errors++; $display("FAIL glitch_short got %0d want 1", frame_err_cnt); end
    ps2_clk = 0;
    repeat (3) @(negedge clk);
    ps2_clk = 1;
    repeat (20) @(negedge clk);
    checks++; if (frame_err_cnt !== 8'd2) begin errors++; $display("FAIL glitch_long got %0d want 2", frame_err_cnt); end
  endtask

  task automatic test_overflow();
    logic [7:0] codes [6];
    codes = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35};
    do_reset();
    send_frame(8'h1C, 1'b1, 11);
    for (int i = 0; i < 6; i++) send_frame(codes[i], 1'b0, 11);
    checks++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL ovf_level got %0d want 4", fifo_level); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %0h want 1", overflow); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (evt_valid !== 1'b1 || evt_code !== codes[i]) begin errors++; $display("FAIL ovf_drain%0d got v=%0h c=%0h want v=1 c=%0h", i, evt_valid, evt_code, codes[i]); end
      pop_one();
    end
    checks++; if (evt_valid !== 1'b0 || fifo_level !== 3'd0) begin errors++; $display("FAIL ovf_empty got v=%0h l=%0d want 0/0", evt_valid, fifo_level); end
    checks++; if (parity_err_cnt !== 8'd1) begin errors++; $display("FAIL ovf_pcnt got %0d want 1", parity_err_cnt); end
    clr_err = 1;
    @(negedge clk);
    clr_err = 0;
    checks++; if (overflow !== 1'b0 || parity_err_cnt !== 8'd0 || frame_err_cnt !== 8'd0) begin errors++; $display("FAIL clr_err got o=%0h p=%0d f=%0d want 0/0/0", overflow, parity_err_cnt, frame_err_cnt); end
  endtask

  task automatic test_reset_midframe();
    do_reset();
    send_frame(8'h1C, 1'b0, 11);
    send_frame(8'h1C, 1'b1, 11);
    send_frame(8'h1C, 1'b0, 4);
    checks++; if (raw_code !== 8'h1C || fifo_level !== 3'd1 || parity_err_cnt !== 8'd1) begin errors++; $display("FAIL mid_pre got rc=%0h l=%0d p=%0d want 1c/1/1", raw_code, fifo_level, parity_err_cnt); end
    @(posedge clk);
    #2 rst = 0;
    #1;
    checks++; if ({evt_valid, evt_code, evt_ext, evt_brk, raw_code, raw_new, overflow} !== 20'd0) begin errors++; $display("FAIL mid_outs got %0h want 0", {evt_valid, evt_code, evt_ext, evt_brk, raw_code, raw_new, overflow}); end
    checks++; if (fifo_level !== 3'd0 || parity_err_cnt !== 8'd0 || frame_err_cnt !== 8'd0) begin errors++; $display("FAIL mid_cnts got l=%0d p=%0d f=%0d want 0/0/0", fifo_level, parity_err_cnt, frame_err_cnt); end
    @(negedge clk);
    ps2_clk = 1; ps2_data = 1;
    repeat (3) @(negedge clk);
    rst = 1;
    repeat (10) @(negedge clk);
    send_frame(8'h1C, 1'b0, 11);
    checks++; if ({evt_valid, evt_ext, evt_brk, evt_code} !== {3'b100, 8'h1C}) begin errors++; $display("FAIL mid_after got %0h want %0h", {evt_valid, evt_ext, evt_brk, evt_code}, {3'b100, 8'h1C}); end
    checks++; if (fifo_level !== 3'd1 || parity_err_cnt !== 8'd0 || frame_err_cnt !== 8'd0) begin errors++; $display("FAIL mid_after_cnts got l=%0d p=%0d f=%0d want 1/0/0", fifo_level, parity_err_cnt, frame_err_cnt); end
  endtask

  initial begin
    test_reset();
    test_single_make();
    test_prefix();
    test_parity();
    test_timeout_glitch();
    test_overflow();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
